cib_scan_controller: RTL and testbench

// Sequences one feature-map channel through the 3x3 conv input buffer.
// - Walks the zero-padded (H+2)x(W+2) frame in raster order.
// - Reads interior pixels from feature memory; border pixels are padding.
// - Drives the buffer's shift, zero-input and size controls.
// - Flags each cycle where a complete 3x3 window is held, and stalls until the PE array accepts it.

---
 rtl/cib_scan_controller_if.sv | 38 +++
 rtl/cib_scan_controller.sv | 130 +++++++++++++
 tb/tb_cib_scan_controller.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/cib_scan_controller_if.sv
// Bus bundle between the 3x3 input-buffer scan controller and its memory, buffer and PE array.
// The master modport is the controller side.
interface cib_scan_controller_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DIM_W  = 5
);
  logic              start;
  logic [2:0]        cfg_size;
  logic [DIM_W-1:0]  cfg_width;
  logic [DIM_W-1:0]  cfg_height;
  logic              cfg_stride2;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] cib_in;
  logic [2:0]        CIB_Size;
  logic              CIB_Shift;
  logic              CIB_Zero_Input;
  logic              win_valid;
  logic [DIM_W-1:0]  win_row;
  logic [DIM_W-1:0]  win_col;
  logic              win_ready;

  modport master (
    input  start, cfg_size, cfg_width, cfg_height, cfg_stride2, mem_rd_data, win_ready,
    output busy, done, mem_rd_en, mem_rd_addr, cib_in, CIB_Size, CIB_Shift, CIB_Zero_Input,
           win_valid, win_row, win_col
  );

  modport slave (
    output start, cfg_size, cfg_width, cfg_height, cfg_stride2, mem_rd_data, win_ready,
    input  busy, done, mem_rd_en, mem_rd_addr, cib_in, CIB_Size, CIB_Shift, CIB_Zero_Input,
           win_valid, win_row, win_col
  );
endinterface

// File: rtl/cib_scan_controller.sv
// Raster-scans one zero-padded feature-map channel through the 3x3 conv input buffer,
// fetching interior pixels, padding the border and handing complete windows to the PE array.
module cib_scan_controller #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DIM_W  = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  cib_scan_controller_if.master bus
);

  localparam int unsigned SIZE_W = 3;

  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, WIN, DONE} state_t;

  state_t            state, state_d;
  logic [DIM_W-1:0]  r, c, r_d, c_d;
  logic [DIM_W-1:0]  w_q, h_q;
  logic              stride2_q;
  logic [SIZE_W-1:0] size_q;

  logic              row_end, last_pos, winhit, step;
  logic [DIM_W-1:0]  r_adv, c_adv;
  logic              interior_d, rd_en_d;
  logic [ADDR_W-1:0] addr_d;

  // Position bookkeeping on the current padded coordinate
  always_comb begin
    row_end  = (c == w_q + DIM_W'(1));
    last_pos = row_end && (r == h_q + DIM_W'(1));
    winhit   = (r >= DIM_W'(2)) && (c >= DIM_W'(2)) && (!stride2_q || (!r[0] && !c[0]));
    c_adv    = row_end ? '0 : c + DIM_W'(1);
    r_adv    = row_end ? r + DIM_W'(1) : r;
    step     = ((state == SHIFT) && !winhit) || ((state == WIN) && bus.win_ready);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      r     <= '0;
      c     <= '0;
    end else begin
      state <= state_d;
      r     <= r_d;
      c     <= c_d;
    end
  end

  always_comb begin
    state_d = state;
    r_d     = r;
    c_d     = c;
    case (state)
      IDLE: begin
        if (bus.start) begin
          r_d     = '0;
          c_d     = '0;
          state_d = ((bus.cfg_width != '0) && (bus.cfg_height != '0)) ? FETCH : DONE;
        end
      end
      FETCH: state_d = SHIFT;
      SHIFT: if (winhit) state_d = WIN;
      WIN:   ;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Shared advance out of SHIFT (no window) and WIN (window accepted)
    if (step) begin
      if (last_pos) begin
        state_d = DONE;
        r_d     = '0;
        c_d     = '0;
      end else begin
        state_d = FETCH;
        r_d     = r_adv;
        c_d     = c_adv;
      end
    end
  end

  // Shadow configuration, captured only when a scan is launched
  always_ff @(posedge CLK) begin
    if (RST) begin
      w_q       <= '0;
      h_q       <= '0;
      stride2_q <= 1'b0;
      size_q    <= '0;
    end else if ((state == IDLE) && bus.start) begin
      w_q       <= bus.cfg_width;
      h_q       <= bus.cfg_height;
      stride2_q <= bus.cfg_stride2;
      size_q    <= bus.cfg_size;
    end
  end

  always_comb begin
    interior_d = (r_d != '0) && (r_d <= h_q) && (c_d != '0) && (c_d <= w_q);
    rd_en_d    = (state_d == FETCH) && interior_d;
    addr_d     = ADDR_W'(ADDR_W'(r_d - DIM_W'(1)) * ADDR_W'(w_q)) + ADDR_W'(c_d - DIM_W'(1));
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.mem_rd_en      <= 1'b0;
      bus.mem_rd_addr    <= '0;
      bus.CIB_Shift      <= 1'b0;
      bus.CIB_Zero_Input <= 1'b0;
      bus.win_valid      <= 1'b0;
      bus.win_row        <= '0;
      bus.win_col        <= '0;
    end else begin
      bus.busy           <= (state_d == FETCH) || (state_d == SHIFT) || (state_d == WIN);
      bus.done           <= (state_d == DONE);
      bus.mem_rd_en      <= rd_en_d;
      if (rd_en_d) bus.mem_rd_addr <= addr_d;
      bus.CIB_Shift      <= (state_d == SHIFT);
      bus.CIB_Zero_Input <= (state_d == SHIFT) && !interior_d;
      bus.win_valid      <= (state_d == WIN);
      bus.win_row        <= (state_d == WIN) ? r_d - DIM_W'(2) : '0;
      bus.win_col        <= (state_d == WIN) ? c_d - DIM_W'(2) : '0;
    end
  end

  assign bus.CIB_Size = size_q;
  assign bus.cib_in   = bus.mem_rd_data;

endmodule

// File: tb/tb_cib_scan_controller.sv
// Directed bench for cib_scan_controller: padded raster scans, strides, window stalls,
// ignored restarts, mid-scan reset and empty maps.
module tb_cib_scan_controller;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DIM_W  = 5;

  logic clk = 1'b0;
  logic rst;

  cib_scan_controller_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W)) bus ();

  cib_scan_controller #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Feature memory: one-cycle read latency, contents tagged by address
  always @(posedge clk) begin
    if (rst) bus.mem_rd_data <= '0;
    else if (bus.mem_rd_en) bus.mem_rd_data <= DATA_W'(16'hA000) + DATA_W'(bus.mem_rd_addr);
  end

  int n_shift, n_zero, first_hold, viol, win_cnt, stall_idx, stall_left;
  logic [ADDR_W-1:0] rd_q[$];
  logic [DATA_W-1:0] dat_q[$];
  logic [15:0]       win_q[$];

  // Observer and PE-array model
  always @(negedge clk) begin
    if (bus.CIB_Shift) begin
      n_shift++;
      if (bus.CIB_Zero_Input) n_zero++;
      else dat_q.push_back(bus.cib_in);
    end
    if (bus.mem_rd_en) rd_q.push_back(bus.mem_rd_addr);
    if (bus.CIB_Shift && bus.win_valid) viol++;
    if (bus.mem_rd_en && (bus.win_valid || bus.CIB_Shift)) viol++;
    if (bus.CIB_Zero_Input && !bus.CIB_Shift) viol++;
    if (bus.win_valid) begin
      if (win_cnt == 0) first_hold++;
      if ((win_cnt == stall_idx) && (stall_left > 0)) begin
        bus.win_ready = 1'b0;
        stall_left--;
      end else begin
        bus.win_ready = 1'b1;
        win_q.push_back({3'b000, bus.win_row, 3'b000, bus.win_col});
        win_cnt++;
      end
    end else begin
      bus.win_ready = 1'b1;
    end
  end

  task automatic clear_stats(input int sidx, input int slen);
    n_shift = 0; n_zero = 0; first_hold = 0; viol = 0; win_cnt = 0;
    stall_idx = sidx; stall_left = slen;
    rd_q.delete(); dat_q.delete(); win_q.delete();
  endtask

  // Launch a scan; done_cyc is the cycle of the done pulse counted from the start cycle (0)
  task automatic run_scan(input int w, input int h, input int s2, input int sidx, input int slen,
                          input int restart_at, output int done_cyc);
    @(posedge clk);
    clear_stats(sidx, slen);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.cfg_width   = DIM_W'(w);
    bus.cfg_height  = DIM_W'(h);
    bus.cfg_stride2 = s2[0];
    bus.cfg_size    = 3'd5;
    done_cyc = -1;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      bus.start     = (i == restart_at);
      bus.cfg_width = (i == restart_at) ? DIM_W'(8) : DIM_W'(w);
      if (bus.done) begin
        done_cyc = i;
        break;
      end
    end
    bus.start = 1'b0;
  endtask

  int d, held, dn;
  logic [15:0] exp_win;

  initial begin
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.cfg_size    = 3'd0;
    bus.cfg_width   = '0;
    bus.cfg_height  = '0;
    bus.cfg_stride2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",      bus.busy, 0);
    check("rst_done",      bus.done, 0);
    check("rst_rd_en",     bus.mem_rd_en, 0);
    check("rst_rd_addr",   bus.mem_rd_addr, 0);
    check("rst_shift",     bus.CIB_Shift, 0);
    check("rst_zero",      bus.CIB_Zero_Input, 0);
    check("rst_size",      bus.CIB_Size, 0);
    check("rst_win_valid", bus.win_valid, 0);
    check("rst_win_rc",    {bus.win_row, bus.win_col}, 0);
    rst = 1'b0;

    // 3x3, stride 1, no backpressure
    run_scan(3, 3, 0, -1, 0, 0, d);
    check("s1_done_cyc", d, 60);
    check("s1_shifts",   n_shift, 25);
    check("s1_zeros",    n_zero, 16);
    check("s1_reads",    rd_q.size(), 9);
    check("s1_wins",     win_q.size(), 9);
    check("s1_size",     bus.CIB_Size, 5);
    check("s1_viol",     viol, 0);
    for (int k = 0; k < 9; k++) begin
      check($sformatf("s1_addr%0d", k), rd_q[k], k);
      check($sformatf("s1_data%0d", k), dat_q[k], 32'hA000 + k);
      exp_win = 16'(((k / 3) << 8) | (k % 3));
      check($sformatf("s1_win%0d", k), win_q[k], exp_win);
    end

    // 4x4, stride 2
    run_scan(4, 4, 1, -1, 0, 0, d);
    check("s2_done_cyc", d, 77);
    check("s2_shifts",   n_shift, 36);
    check("s2_zeros",    n_zero, 20);
    check("s2_reads",    rd_q.size(), 16);
    check("s2_wins",     win_q.size(), 4);
    check("s2_win0",     win_q[0], 16'h0000);
    check("s2_win1",     win_q[1], 16'h0002);
    check("s2_win2",     win_q[2], 16'h0200);
    check("s2_win3",     win_q[3], 16'h0202);
    check("s2_addr15",   rd_q[15], 15);
    check("s2_data15",   dat_q[15], 32'hA00F);
    check("s2_viol",     viol, 0);

    // 3x3 with the first window held off for 5 cycles
    run_scan(3, 3, 0, 0, 5, 0, d);
    check("st_done_cyc", d, 65);
    check("st_hold",     first_hold, 6);
    check("st_win0",     win_q[0], 16'h0000);
    check("st_wins",     win_q.size(), 9);
    check("st_shifts",   n_shift, 25);
    check("st_viol",     viol, 0);

    // Restart with a different width mid-scan must be ignored
    run_scan(3, 3, 0, -1, 0, 10, d);
    check("rs_done_cyc", d, 60);
    check("rs_reads",    rd_q.size(), 9);
    check("rs_addr8",    rd_q[8], 8);
    check("rs_wins",     win_q.size(), 9);
    check("rs_win8",     win_q[8], 16'h0202);

    // Reset during the stall of the 4th window
    @(posedge clk);
    clear_stats(3, 1000);
    @(negedge clk);
    bus.start = 1'b1; bus.cfg_width = DIM_W'(3); bus.cfg_height = DIM_W'(3); bus.cfg_stride2 = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    held = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.win_valid && (win_cnt == 3)) held++;
      else held = 0;
      if (held >= 2) break;
    end
    check("rr_reached_win3", held, 2);
    rst = 1'b1;
    @(negedge clk);
    check("rr_busy",  bus.busy, 0);
    check("rr_valid", bus.win_valid, 0);
    check("rr_shift", bus.CIB_Shift, 0);
    check("rr_done",  bus.done, 0);
    rst = 1'b0;
    stall_left = 0;
    dn = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    check("rr_no_done", dn, 0);
    check("rr_idle",    bus.busy, 0);

    // Empty maps finish immediately
    run_scan(0, 3, 0, -1, 0, 0, d);
    check("w0_done_cyc", d, 1);
    check("w0_shifts",   n_shift, 0);
    check("w0_reads",    rd_q.size(), 0);
    run_scan(3, 0, 0, -1, 0, 0, d);
    check("h0_done_cyc", d, 1);
    check("h0_shifts",   n_shift, 0);
    check("h0_reads",    rd_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
